// File: rtl/move_responder_if.sv
// Bundles the player-request, map-BRAM and response signals of move_responder.
// MOVE_STATS_EN adds the move/reject counters to the bundle.
interface move_responder_if;
  logic [15:0] floor;
  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic [31:0] key_num;
  logic [15:0] health;
  logic        player_ask_move;
  logic [3:0]  player_ask_x;
  logic [3:0]  player_ask_y;
  logic [18:0] bRAM_map_addr;
  logic [15:0] bRAM_map_data;
  logic        bRAM_map_wr;
  logic [15:0] bRAM_map_dwrite;
  logic        accept_move;
  logic        reject_move;
  logic        busy;
  logic [3:0]  goto_x;
  logic [3:0]  goto_y;
  logic [15:0] floor_out;
  logic [31:0] key_num_out;
  logic [15:0] health_out;
`ifdef MOVE_STATS_EN
  logic [15:0] move_count;
  logic [15:0] reject_count;

  modport slave (
    input  floor, player_x, player_y, key_num, health,
           player_ask_move, player_ask_x, player_ask_y, bRAM_map_data,
    output bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite, accept_move, reject_move, busy,
           goto_x, goto_y, floor_out, key_num_out, health_out, move_count, reject_count
  );
  modport master (
    output floor, player_x, player_y, key_num, health,
           player_ask_move, player_ask_x, player_ask_y, bRAM_map_data,
    input  bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite, accept_move, reject_move, busy,
           goto_x, goto_y, floor_out, key_num_out, health_out, move_count, reject_count
  );
`else
  modport slave (
    input  floor, player_x, player_y, key_num, health,
           player_ask_move, player_ask_x, player_ask_y, bRAM_map_data,
    output bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite, accept_move, reject_move, busy,
           goto_x, goto_y, floor_out, key_num_out, health_out
  );
  modport master (
    output floor, player_x, player_y, key_num, health,
           player_ask_move, player_ask_x, player_ask_y, bRAM_map_data,
    input  bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite, accept_move, reject_move, busy,
           goto_x, goto_y, floor_out, key_num_out, health_out
  );
`endif
endinterface

// File: rtl/move_responder.sv
// Resolves a player move against the map tile in BRAM, clears consumed tiles and returns the new state.
// Optional MOVE_STATS_EN adds wrapping accept/reject counters.
module move_responder #(
  parameter int MAP_W      = 13,
  parameter int MAP_H      = 13,
  parameter int NUM_FLOORS = 16,
  parameter int RD_LAT     = 1
) (
  input logic             clk,
  input logic             rstn,
  move_responder_if.slave mr
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;
  localparam int WCW       = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  logic [2:0]     r_state;
  logic [WCW-1:0] r_wait;
  logic           r_busy, r_accept, r_reject, r_wr, r_ok;
  logic [18:0]    r_addr;
  logic [15:0]    r_floor, r_health, r_nfloor, r_nhealth, r_floor_out, r_health_out;
  logic [31:0]    r_keys, r_nkeys, r_keys_out;
  logic [3:0]     r_px, r_py, r_tx, r_ty, r_goto_x, r_goto_y;

  logic [7:0]  w_type, w_v, w_kbyte;
  logic [1:0]  w_c;
  logic [16:0] w_sum;
  logic        w_ok, w_consume, w_in_range;
  logic [15:0] w_nfloor, w_nhealth;
  logic [31:0] w_nkeys;

  assign w_type     = mr.bRAM_map_data[15:8];
  assign w_v        = mr.bRAM_map_data[7:0];
  assign w_c        = w_v[1:0];
  assign w_kbyte    = r_keys[{w_c, 3'b000} +: 8];
  assign w_sum      = {1'b0, r_health} + {9'd0, w_v};
  assign w_in_range = (int'(mr.player_ask_x) < MAP_W) && (int'(mr.player_ask_y) < MAP_H);

  // Tile rule on the snapshot; w_consume marks tiles that must be cleared in BRAM.
  always_comb begin
    w_ok      = 1'b0;
    w_consume = 1'b0;
    w_nfloor  = r_floor;
    w_nhealth = r_health;
    w_nkeys   = r_keys;
    case (w_type)
      8'd0: w_ok = 1'b1;
      8'd2: begin
        w_ok      = 1'b1;
        w_consume = 1'b1;
        w_nkeys[{w_c, 3'b000} +: 8] = (w_kbyte == 8'hFF) ? w_kbyte : w_kbyte + 8'd1;
      end
      8'd3: if (w_kbyte != 8'd0) begin
        w_ok      = 1'b1;
        w_consume = 1'b1;
        w_nkeys[{w_c, 3'b000} +: 8] = w_kbyte - 8'd1;
      end
      8'd4: begin
        w_ok      = 1'b1;
        w_consume = 1'b1;
        w_nhealth = w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
      8'd5: if (r_health > {8'd0, w_v}) begin
        w_ok      = 1'b1;
        w_consume = 1'b1;
        w_nhealth = r_health - {8'd0, w_v};
      end
      8'd6: if (int'(r_floor) < NUM_FLOORS - 1) begin
        w_ok     = 1'b1;
        w_nfloor = r_floor + 16'd1;
      end
      8'd7: if (r_floor != 16'd0) begin
        w_ok     = 1'b1;
        w_nfloor = r_floor - 16'd1;
      end
      default: w_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_busy       <= 1'b0;
      r_accept     <= 1'b0;
      r_reject     <= 1'b0;
      r_wr         <= 1'b0;
      r_ok         <= 1'b0;
      r_addr       <= '0;
      r_floor      <= '0;
      r_health     <= '0;
      r_keys       <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_tx         <= '0;
      r_ty         <= '0;
      r_nfloor     <= '0;
      r_nhealth    <= '0;
      r_nkeys      <= '0;
      r_goto_x     <= '0;
      r_goto_y     <= '0;
      r_floor_out  <= '0;
      r_health_out <= '0;
      r_keys_out   <= '0;
    end else begin
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_wr     <= 1'b0;
      // busy covers the response pulse cycle, so a new ask is taken only after it
      if (r_accept || r_reject) r_busy <= 1'b0;
      case (r_state)
        S_IDLE: if (mr.player_ask_move && !r_busy) begin
          r_busy   <= 1'b1;
          r_floor  <= mr.floor;
          r_keys   <= mr.key_num;
          r_health <= mr.health;
          r_px     <= mr.player_x;
          r_py     <= mr.player_y;
          r_tx     <= mr.player_ask_x;
          r_ty     <= mr.player_ask_y;
          if (w_in_range) begin
            r_addr  <= {mr.floor[10:0], mr.player_ask_y, mr.player_ask_x};
            r_state <= S_READ;
          end else begin
            r_ok    <= 1'b0;
            r_state <= S_RESP;
          end
        end
        S_READ: begin
          r_wait  <= WCW'(WAIT_INIT);
          r_state <= (RD_LAT == 1) ? S_EVAL : S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == '0) r_state <= S_EVAL;
          else              r_wait  <= r_wait - WCW'(1);
        end
        S_EVAL: begin
          r_ok      <= w_ok;
          r_wr      <= w_consume;
          r_nfloor  <= w_nfloor;
          r_nhealth <= w_nhealth;
          r_nkeys   <= w_nkeys;
          r_state   <= S_WRITE;
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP: begin
          r_accept     <= r_ok;
          r_reject     <= !r_ok;
          r_goto_x     <= r_ok ? r_tx : r_px;
          r_goto_y     <= r_ok ? r_ty : r_py;
          r_floor_out  <= r_ok ? r_nfloor : r_floor;
          r_health_out <= r_ok ? r_nhealth : r_health;
          r_keys_out   <= r_ok ? r_nkeys : r_keys;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mr.bRAM_map_addr   = r_addr;
  assign mr.bRAM_map_wr     = r_wr;
  assign mr.bRAM_map_dwrite = 16'h0000;
  assign mr.accept_move     = r_accept;
  assign mr.reject_move     = r_reject;
  assign mr.busy            = r_busy;
  assign mr.goto_x          = r_goto_x;
  assign mr.goto_y          = r_goto_y;
  assign mr.floor_out       = r_floor_out;
  assign mr.key_num_out     = r_keys_out;
  assign mr.health_out      = r_health_out;

`ifdef MOVE_STATS_EN
  logic [15:0] r_move_count, r_reject_count;

  // Counters follow the response pulses and wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_move_count   <= '0;
      r_reject_count <= '0;
    end else begin
      if (r_accept) r_move_count   <= r_move_count + 16'd1;
      if (r_reject) r_reject_count <= r_reject_count + 16'd1;
    end
  end

  assign mr.move_count   = r_move_count;
  assign mr.reject_count = r_reject_count;
`endif
endmodule

// File: tb/tb_move_responder.sv
// Self-checking bench for move_responder: directed tile cases, random moves against a
// behavioural tile-rule model, dropped asks while busy, and reset in the middle of a move.
module tb_move_responder;
  localparam int MAP_W      = 13;
  localparam int MAP_H      = 13;
  localparam int NUM_FLOORS = 16;
  localparam int RD_LAT     = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  move_responder_if bus();

  move_responder #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .NUM_FLOORS(NUM_FLOORS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .mr(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [18:0] expAddr  = '0;
  logic [15:0] tileWord = '0;
  int          wrCount  = 0;
  logic [18:0] wrAddr   = '0;
  logic [15:0] wrData   = '0;

  typedef struct {
    bit          ok;
    bit          cons;
    logic [15:0] fl;
    logic [31:0] keys;
    logic [15:0] hp;
  } resT;

  typedef struct {
    string       name;
    logic [15:0] tile;
    logic [15:0] fl;
    logic [31:0] keys;
    logic [15:0] hp;
    logic [3:0]  px, py, tx, ty;
  } caseT;

  // Map BRAM stand-in: only the expected address holds the tile, anything else reads as junk.
  always @(posedge clk)
    bus.bRAM_map_data <= (bus.bRAM_map_addr == expAddr) ? tileWord : 16'hDEAD;

  // Record every write strobe seen by the map.
  always @(negedge clk)
    if (bus.bRAM_map_wr === 1'b1) begin
      wrCount = wrCount + 1;
      wrAddr  = bus.bRAM_map_addr;
      wrData  = bus.bRAM_map_dwrite;
    end

  // Tile rules written as plain arithmetic on integers.
  function automatic resT refModel(logic [15:0] tile, logic [15:0] fl, logic [31:0] keys,
                                   logic [15:0] hp);
    resT r;
    int  kind, v, c, kb, h;
    r.ok = 0; r.cons = 0; r.fl = fl; r.keys = keys; r.hp = hp;
    kind = int'(tile[15:8]);
    v    = int'(tile[7:0]);
    c    = v % 4;
    kb   = int'((keys >> (8 * c)) & 32'hFF);
    case (kind)
      0: r.ok = 1;
      2: begin r.ok = 1; r.cons = 1; kb = (kb == 255) ? 255 : kb + 1; end
      3: if (kb > 0) begin r.ok = 1; r.cons = 1; kb = kb - 1; end
      4: begin
        r.ok = 1; r.cons = 1;
        h = int'(hp) + v;
        if (h > 65535) h = 65535;
        r.hp = 16'(h);
      end
      5: if (int'(hp) > v) begin r.ok = 1; r.cons = 1; r.hp = 16'(int'(hp) - v); end
      6: if (int'(fl) + 1 < NUM_FLOORS) begin r.ok = 1; r.fl = 16'(int'(fl) + 1); end
      7: if (fl != 16'd0) begin r.ok = 1; r.fl = 16'(int'(fl) - 1); end
      default: r.ok = 0;
    endcase
    if (r.ok && (kind == 2 || kind == 3))
      r.keys = (keys & ~(32'hFF << (8 * c))) | (32'(kb) << (8 * c));
    return r;
  endfunction

  function automatic resT expected(caseT t);
    resT e;
    if (int'(t.tx) >= MAP_W || int'(t.ty) >= MAP_H) begin
      e.ok = 0; e.cons = 0; e.fl = t.fl; e.keys = t.keys; e.hp = t.hp;
    end else begin
      e = refModel(t.tile, t.fl, t.keys, t.hp);
    end
    return e;
  endfunction

  // Issues one move request and waits (bounded) for the response pulse.
  task automatic applyStimulus(input caseT t, output int lat, output int wrs,
                               output logic busyEarly);
    int wr0;
    @(posedge clk);
    @(negedge clk);
    bus.floor           = t.fl;
    bus.key_num         = t.keys;
    bus.health          = t.hp;
    bus.player_x        = t.px;
    bus.player_y        = t.py;
    bus.player_ask_x    = t.tx;
    bus.player_ask_y    = t.ty;
    tileWord            = t.tile;
    expAddr             = {t.fl[10:0], t.ty, t.tx};
    bus.player_ask_move = 1'b1;
    wr0                 = wrCount;
    @(posedge clk);
    #1;
    bus.player_ask_move = 1'b0;
    busyEarly           = bus.busy;
    lat                 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.accept_move === 1'b1 || bus.reject_move === 1'b1) begin
        lat = n;
        break;
      end
    end
    wrs = wrCount - wr0;
  endtask

  task automatic test_reset();
    bus.player_ask_move = 1'b0;
    bus.floor = '0; bus.key_num = '0; bus.health = '0;
    bus.player_x = '0; bus.player_y = '0; bus.player_ask_x = '0; bus.player_ask_y = '0;
    #3 rstn = 1'b0;
    #2;
    total++;
    if ({bus.accept_move, bus.reject_move, bus.busy, bus.bRAM_map_wr} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=0000",
               {bus.accept_move, bus.reject_move, bus.busy, bus.bRAM_map_wr});
    end
    total++;
    if (bus.bRAM_map_addr !== 19'd0 || bus.bRAM_map_dwrite !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_bram got=%h/%h want=0/0", bus.bRAM_map_addr, bus.bRAM_map_dwrite);
    end
    total++;
    if ({bus.goto_x, bus.goto_y, bus.floor_out, bus.key_num_out, bus.health_out} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h,%h,%h,%h,%h want=0", bus.goto_x, bus.goto_y,
               bus.floor_out, bus.key_num_out, bus.health_out);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.accept_move !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release got=busy %b accept %b want=0 0", bus.busy, bus.accept_move);
    end
  endtask

  task automatic test_tiles();
    caseT items[$];
    resT  e;
    int   lat, wrs, explat;
    logic busyEarly;
    items.push_back('{"floor_tile",  16'h0000, 16'd3,  32'h00000000, 16'd50,    4'd6, 4'd10, 4'd6,  4'd9});
    items.push_back('{"key_tile",    16'h0201, 16'd1,  32'h00000000, 16'd10,    4'd2, 4'd2,  4'd3,  4'd2});
    items.push_back('{"key_sat",     16'h0203, 16'd1,  32'hFF000000, 16'd10,    4'd3, 4'd2,  4'd4,  4'd2});
    items.push_back('{"door_locked", 16'h0300, 16'd2,  32'h00000000, 16'd10,    4'd5, 4'd5,  4'd5,  4'd4});
    items.push_back('{"door_open",   16'h0300, 16'd2,  32'h00000001, 16'd10,    4'd5, 4'd5,  4'd5,  4'd4});
    items.push_back('{"monster_win", 16'h0514, 16'd0,  32'h00000000, 16'd20,    4'd1, 4'd1,  4'd1,  4'd0});
    items.push_back('{"monster_ok",  16'h0514, 16'd0,  32'h00000000, 16'd21,    4'd1, 4'd1,  4'd1,  4'd0});
    items.push_back('{"potion_sat",  16'h04FF, 16'd7,  32'h00000000, 16'hFFF0,  4'd8, 4'd8,  4'd9,  4'd8});
    items.push_back('{"up_top",      16'h0600, 16'd15, 32'h00000000, 16'd5,     4'd0, 4'd0,  4'd0,  4'd1});
    items.push_back('{"up_mid",      16'h0600, 16'd4,  32'h00000000, 16'd5,     4'd0, 4'd0,  4'd0,  4'd1});
    items.push_back('{"down_ground", 16'h0700, 16'd0,  32'h00000000, 16'd5,     4'd12, 4'd12, 4'd11, 4'd12});
    items.push_back('{"wall",        16'h0100, 16'd9,  32'h01020304, 16'd9,     4'd7, 4'd7,  4'd7,  4'd6});
    items.push_back('{"oor_x",       16'h0000, 16'd3,  32'h00000000, 16'd50,    4'd12, 4'd4, 4'd13, 4'd4});
    items.push_back('{"oor_y",       16'h0000, 16'd3,  32'h00000000, 16'd50,    4'd4, 4'd12, 4'd4,  4'd13});
    foreach (items[i]) begin
      e      = expected(items[i]);
      explat = (int'(items[i].tx) >= MAP_W || int'(items[i].ty) >= MAP_H) ? 1 : RD_LAT + 3;
      applyStimulus(items[i], lat, wrs, busyEarly);
      total++;
      if (lat !== explat) begin
        bad++; $display("[TB] FAIL %s latency got=%0d want=%0d", items[i].name, lat, explat);
      end
      total++;
      if (busyEarly !== 1'b1) begin
        bad++; $display("[TB] FAIL %s busy got=%b want=1", items[i].name, busyEarly);
      end
      total++;
      if ({bus.accept_move, bus.reject_move} !== {e.ok, !e.ok}) begin
        bad++; $display("[TB] FAIL %s verdict got=%b%b want=%b%b", items[i].name,
                        bus.accept_move, bus.reject_move, e.ok, !e.ok);
      end
      total++;
      if ({bus.goto_x, bus.goto_y} !== (e.ok ? {items[i].tx, items[i].ty} : {items[i].px, items[i].py})) begin
        bad++; $display("[TB] FAIL %s goto got=(%0d,%0d) want_ok=%b", items[i].name,
                        bus.goto_x, bus.goto_y, e.ok);
      end
      total++;
      if ({bus.floor_out, bus.key_num_out, bus.health_out} !== {e.fl, e.keys, e.hp}) begin
        bad++; $display("[TB] FAIL %s state got=%h,%h,%h want=%h,%h,%h", items[i].name,
                        bus.floor_out, bus.key_num_out, bus.health_out, e.fl, e.keys, e.hp);
      end
      total++;
      if (wrs !== (e.cons ? 1 : 0)) begin
        bad++; $display("[TB] FAIL %s write_count got=%0d want=%0d", items[i].name, wrs, e.cons ? 1 : 0);
      end
      if (e.cons) begin
        total++;
        if (wrData !== 16'h0000 || wrAddr !== expAddr) begin
          bad++; $display("[TB] FAIL %s write got=%h@%h want=0000@%h", items[i].name, wrData, wrAddr, expAddr);
        end
      end
      if (explat != 1) begin
        total++;
        if (bus.bRAM_map_addr !== expAddr) begin
          bad++; $display("[TB] FAIL %s addr got=%h want=%h", items[i].name, bus.bRAM_map_addr, expAddr);
        end
      end
      @(posedge clk);
      #1;
      total++;
      if ({bus.accept_move, bus.reject_move, bus.busy} !== 3'b000) begin
        bad++; $display("[TB] FAIL %s after_pulse got=%b want=000", items[i].name,
                        {bus.accept_move, bus.reject_move, bus.busy});
      end
    end
  endtask

  task automatic test_random();
    caseT t;
    resT  e;
    int   lat, wrs, explat, sel;
    logic busyEarly;
    for (int k = 0; k < 60; k++) begin
      t.name = "random";
      t.tile = {8'($urandom_range(0, 8)), 8'($urandom_range(0, 255))};
      t.fl   = 16'($urandom_range(0, NUM_FLOORS - 1));
      for (int b = 0; b < 4; b++) begin
        sel = int'($urandom_range(0, 3));
        t.keys[8*b +: 8] = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      end
      t.hp = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 300)) : 16'($urandom_range(65000, 65535));
      t.px = 4'($urandom_range(0, MAP_W - 1));
      t.py = 4'($urandom_range(0, MAP_H - 1));
      t.tx = 4'($urandom_range(0, 14));
      t.ty = 4'($urandom_range(0, 14));
      e      = expected(t);
      explat = (int'(t.tx) >= MAP_W || int'(t.ty) >= MAP_H) ? 1 : RD_LAT + 3;
      applyStimulus(t, lat, wrs, busyEarly);
      total++;
      if (lat !== explat || {bus.accept_move, bus.reject_move} !== {e.ok, !e.ok}) begin
        bad++; $display("[TB] FAIL rnd%0d tile=%h lat/verdict got=%0d/%b%b want=%0d/%b%b", k, t.tile,
                        lat, bus.accept_move, bus.reject_move, explat, e.ok, !e.ok);
      end
      total++;
      if ({bus.goto_x, bus.goto_y} !== (e.ok ? {t.tx, t.ty} : {t.px, t.py})) begin
        bad++; $display("[TB] FAIL rnd%0d goto got=(%0d,%0d) want_ok=%b", k, bus.goto_x, bus.goto_y, e.ok);
      end
      total++;
      if ({bus.floor_out, bus.key_num_out, bus.health_out} !== {e.fl, e.keys, e.hp}) begin
        bad++; $display("[TB] FAIL rnd%0d tile=%h state got=%h,%h,%h want=%h,%h,%h", k, t.tile,
                        bus.floor_out, bus.key_num_out, bus.health_out, e.fl, e.keys, e.hp);
      end
      total++;
      if (wrs !== (e.cons ? 1 : 0)) begin
        bad++; $display("[TB] FAIL rnd%0d tile=%h write_count got=%0d want=%0d", k, t.tile, wrs, e.cons ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [3:0] firstX = '0;
    @(posedge clk);
    @(negedge clk);
    bus.floor = 16'd5; bus.key_num = 32'd0; bus.health = 16'd30;
    bus.player_x = 4'd2; bus.player_y = 4'd3;
    bus.player_ask_x = 4'd2; bus.player_ask_y = 4'd2;
    tileWord = 16'h0000;
    expAddr  = {11'd5, 4'd2, 4'd2};
    bus.player_ask_move = 1'b1;
    @(posedge clk);
    #1 bus.player_ask_move = 1'b0;
    @(negedge clk);
    bus.player_ask_x = 4'd5;
    bus.player_ask_move = 1'b1;
    @(posedge clk);
    #1 bus.player_ask_move = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (bus.accept_move === 1'b1 || bus.reject_move === 1'b1) begin
        if (pulses == 0) firstX = bus.goto_x;
        pulses++;
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("[TB] FAIL busy_drop pulses got=%0d want=1", pulses);
    end
    total++;
    if (firstX !== 4'd2 || bus.bRAM_map_addr !== expAddr) begin
      bad++; $display("[TB] FAIL busy_drop target got=x%0d addr %h want=x2 addr %h", firstX,
                      bus.bRAM_map_addr, expAddr);
    end
  endtask

  task automatic test_reset_mid();
    int wr0;
    @(posedge clk);
    @(negedge clk);
    bus.floor = 16'd2; bus.key_num = 32'd0; bus.health = 16'd40;
    bus.player_x = 4'd1; bus.player_y = 4'd2;
    bus.player_ask_x = 4'd1; bus.player_ask_y = 4'd1;
    tileWord = 16'h0202;
    expAddr  = {11'd2, 4'd1, 4'd1};
    wr0 = wrCount;
    bus.player_ask_move = 1'b1;
    @(posedge clk);
    #1 bus.player_ask_move = 1'b0;
    repeat (RD_LAT) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    total++;
    if ({bus.accept_move, bus.reject_move, bus.busy, bus.bRAM_map_wr, bus.bRAM_map_addr,
         bus.bRAM_map_dwrite} !== '0) begin
      bad++; $display("[TB] FAIL midreset_ctrl got=%b%b%b%b addr %h want=0", bus.accept_move,
                      bus.reject_move, bus.busy, bus.bRAM_map_wr, bus.bRAM_map_addr);
    end
    total++;
    if ({bus.goto_x, bus.goto_y, bus.floor_out, bus.key_num_out, bus.health_out} !== '0) begin
      bad++; $display("[TB] FAIL midreset_state got=%h,%h,%h,%h,%h want=0", bus.goto_x, bus.goto_y,
                      bus.floor_out, bus.key_num_out, bus.health_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (wrCount !== wr0) begin
      bad++; $display("[TB] FAIL midreset_write got=%0d writes want=0", wrCount - wr0);
    end
    total++;
    if ({bus.accept_move, bus.reject_move, bus.busy} !== 3'b000) begin
      bad++; $display("[TB] FAIL midreset_idle got=%b want=000", {bus.accept_move, bus.reject_move, bus.busy});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=still running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_tiles();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
